// File: rtl/freq_meter.sv
// freq_meter: counts rising edges of a synchronized signal over a programmable gate window.
// Define FREQ_METER_PERIOD_EN to build the edge-to-edge period measurement.
module freq_meter #(
    parameter int GATE_W = 16,
    parameter int CNT_W  = 16
) (
    input  logic              inClk,
    input  logic              reset,
    input  logic              sigIn,
    input  logic              start,
    input  logic [GATE_W-1:0] gateLen,
    output logic              busy,
    output logic              done,
    output logic [CNT_W-1:0]  edgeCount,
    output logic              overflow,
    output logic [CNT_W-1:0]  period
);
    typedef enum logic [0:0] {IDLE = 1'b0, GATE = 1'b1} state_t;

    localparam logic [CNT_W-1:0]  CNT_MAX  = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0]  CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [GATE_W-1:0] GATE_ONE = GATE_W'(1);
    localparam logic [GATE_W-1:0] GATE_ZERO = {GATE_W{1'b0}};

    state_t            state_r;
    logic              s1_r, s2_r, s3_r;
    logic              edge_s;
    logic [GATE_W-1:0] gate_cnt_r;
    logic [CNT_W-1:0]  work_cnt_r;
    logic [CNT_W-1:0]  cnt_next_s;
    logic              work_ovf_r;
    logic              ovf_next_s;
    logic              last_cycle_s;

    assign edge_s       = s2_r & ~s3_r;
    assign last_cycle_s = (state_r == GATE) && (gate_cnt_r == GATE_ONE);

    // Working count and flag as they stand after this cycle's edge (saturating).
    always_comb begin
        cnt_next_s = work_cnt_r;
        ovf_next_s = work_ovf_r;
        if (edge_s) begin
            if (work_cnt_r == CNT_MAX) begin
                ovf_next_s = 1'b1;
            end else begin
                cnt_next_s = work_cnt_r + CNT_ONE;
            end
        end else begin
            cnt_next_s = work_cnt_r;
        end
    end

    // Synchronizer, gate FSM and registered result outputs.
    always_ff @(posedge inClk) begin
        if (!reset) begin
            state_r    <= IDLE;
            s1_r       <= 1'b0;
            s2_r       <= 1'b0;
            s3_r       <= 1'b0;
            gate_cnt_r <= GATE_ZERO;
            work_cnt_r <= CNT_ZERO;
            work_ovf_r <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            edgeCount  <= CNT_ZERO;
            overflow   <= 1'b0;
        end else begin
            s1_r <= sigIn;
            s2_r <= s1_r;
            s3_r <= s2_r;
            done <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (start) begin
                        if (gateLen != GATE_ZERO) begin
                            gate_cnt_r <= gateLen;
                            work_cnt_r <= CNT_ZERO;
                            work_ovf_r <= 1'b0;
                            busy       <= 1'b1;
                            state_r    <= GATE;
                        end else begin
                            done      <= 1'b1;
                            edgeCount <= CNT_ZERO;
                            overflow  <= 1'b0;
                        end
                    end else begin
                        busy <= 1'b0;
                    end
                end
                GATE: begin
                    work_cnt_r <= cnt_next_s;
                    work_ovf_r <= ovf_next_s;
                    gate_cnt_r <= gate_cnt_r - GATE_ONE;
                    if (gate_cnt_r == GATE_ONE) begin
                        edgeCount <= cnt_next_s;
                        overflow  <= ovf_next_s;
                        done      <= 1'b1;
                        busy      <= 1'b0;
                        state_r   <= IDLE;
                    end else begin
                        busy <= 1'b1;
                    end
                end
                default: begin
                    busy    <= 1'b0;
                    state_r <= IDLE;
                end
            endcase
        end
    end

`ifdef FREQ_METER_PERIOD_EN
    logic [CNT_W-1:0] ival_r;
    logic [CNT_W-1:0] ival_next_s;
    logic [CNT_W-1:0] last_per_r;
    logic [CNT_W-1:0] per_next_s;
    logic             seen_r;
    logic [CNT_W-1:0] period_r;

    // ival_r restarts at 1 on each edge, so at the next edge it equals the edge spacing.
    always_comb begin
        ival_next_s = (ival_r == CNT_MAX) ? ival_r : (ival_r + CNT_ONE);
        per_next_s  = last_per_r;
        if (edge_s) begin
            ival_next_s = CNT_ONE;
            if (seen_r) begin
                per_next_s = ival_r;
            end else begin
                per_next_s = last_per_r;
            end
        end else begin
            per_next_s = last_per_r;
        end
    end

    // Period tracker, cleared on window start and published with the edge count.
    always_ff @(posedge inClk) begin
        if (!reset) begin
            ival_r     <= CNT_ZERO;
            last_per_r <= CNT_ZERO;
            seen_r     <= 1'b0;
            period_r   <= CNT_ZERO;
        end else if (state_r == IDLE) begin
            if (start) begin
                ival_r     <= CNT_ZERO;
                last_per_r <= CNT_ZERO;
                seen_r     <= 1'b0;
                if (gateLen == GATE_ZERO) begin
                    period_r <= CNT_ZERO;
                end else begin
                    period_r <= period_r;
                end
            end else begin
                period_r <= period_r;
            end
        end else begin
            ival_r     <= ival_next_s;
            last_per_r <= per_next_s;
            seen_r     <= seen_r | edge_s;
            if (last_cycle_s) begin
                period_r <= per_next_s;
            end else begin
                period_r <= period_r;
            end
        end
    end

    assign period = period_r;
`else
    assign period = CNT_ZERO;
`endif

endmodule

// File: tb/tb_freq_meter.sv
// Self-checking bench for freq_meter: a 16-bit and a 4-bit counter instance share stimulus.
module tb_freq_meter;
    localparam int GW = 16;

    logic          inClk = 1'b0;
    logic          reset;
    logic          sigIn;
    logic          start;
    logic [GW-1:0] gateLen;
    logic          busy, done, overflow;
    logic [15:0]   edgeCount, period;
    logic          busy4, done4, overflow4;
    logic [3:0]    edgeCount4, period4;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int sig_p    = 0;
    int sig_ph   = 0;
    int rises[$];

    freq_meter #(.GATE_W(GW), .CNT_W(16)) dut (
        .inClk(inClk), .reset(reset), .sigIn(sigIn), .start(start), .gateLen(gateLen),
        .busy(busy), .done(done), .edgeCount(edgeCount), .overflow(overflow), .period(period)
    );

    freq_meter #(.GATE_W(GW), .CNT_W(4)) dut4 (
        .inClk(inClk), .reset(reset), .sigIn(sigIn), .start(start), .gateLen(gateLen),
        .busy(busy4), .done(done4), .edgeCount(edgeCount4), .overflow(overflow4), .period(period4)
    );

    always #5 inClk = ~inClk;
    always @(posedge inClk) cyc <= cyc + 1;

    // Periodic square wave of period sig_p and phase sig_ph; every rising edge is logged.
    initial begin : sig_gen
        logic prev;
        prev  = 1'b0;
        sigIn = 1'b0;
        forever begin
            @(posedge inClk); #1;
            if (sig_p > 1) sigIn = (((cyc + sig_ph) % sig_p) < (sig_p / 2));
            else sigIn = 1'b0;
            if (sigIn && !prev) rises.push_back(cyc);
            prev = sigIn;
        end
    end

    // Reference: a rise in cycle c is seen in cycle c+2; it counts if that cycle lies in T+1..T+n.
    task automatic model(input int t, input int n, input int w, output int cnt, output int ovf, output int per);
        int k, last, prv, mx;
        k = 0; last = -1; prv = -1; mx = (1 << w) - 1;
        foreach (rises[i]) begin
            if ((rises[i] + 2 >= t + 1) && (rises[i] + 2 <= t + n)) begin
                k++;
                prv  = last;
                last = rises[i] + 2;
            end
        end
        cnt = (k > mx) ? mx : k;
        ovf = (k > mx) ? 1 : 0;
        per = (k >= 2) ? (((last - prv) > mx) ? mx : (last - prv)) : 0;
`ifndef FREQ_METER_PERIOD_EN
        per = 0;
`endif
    endtask

    task automatic launch(input int n, output int t);
        @(posedge inClk); #1;
        gateLen = GW'(n);
        start   = 1'b1;
        t       = cyc;
        @(posedge inClk); #1;
        start = 1'b0;
    endtask

    task automatic collect(input int span, output int done_cyc, output int busy_cnt, output int ndone);
        done_cyc = -1; busy_cnt = 0; ndone = 0;
        for (int i = 0; i < span; i++) begin
            @(negedge inClk);
            if (busy === 1'b1) busy_cnt++;
            if (done === 1'b1) begin
                ndone++;
                if (done_cyc < 0) done_cyc = cyc;
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b0; start = 1'b0; gateLen = '0;
        repeat (3) @(posedge inClk);
        @(negedge inClk);
        n_checks++;
        if ({busy, done, overflow, edgeCount, period} !== 35'd0) begin
            n_fail++; $display("FAIL reset_outputs: got %h expected 0", {busy, done, overflow, edgeCount, period});
        end
        n_checks++;
        if ({busy4, done4, overflow4, edgeCount4, period4} !== 11'd0) begin
            n_fail++; $display("FAIL reset_outputs4: got %h expected 0", {busy4, done4, overflow4, edgeCount4, period4});
        end
        @(posedge inClk); #1;
        reset = 1'b1;
    endtask

    task automatic test_basic();
        int t, dc, bc, nd, cnt, ovf, per;
        sig_p = 4; sig_ph = 0;
        repeat (8) @(posedge inClk);
        launch(100, t);
        collect(110, dc, bc, nd);
        model(t, 100, 16, cnt, ovf, per);
        n_checks++; if (dc !== t + 101) begin n_fail++; $display("FAIL basic_done_cycle: got %0d expected %0d", dc, t + 101); end
        n_checks++; if (bc !== 100) begin n_fail++; $display("FAIL basic_busy_cycles: got %0d expected 100", bc); end
        n_checks++; if (nd !== 1) begin n_fail++; $display("FAIL basic_done_pulses: got %0d expected 1", nd); end
        n_checks++; if (edgeCount !== 16'd25) begin n_fail++; $display("FAIL basic_count: got %0d expected 25", edgeCount); end
        n_checks++; if (edgeCount !== 16'(cnt)) begin n_fail++; $display("FAIL basic_count_model: got %0d expected %0d", edgeCount, cnt); end
        n_checks++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL basic_overflow: got %0d expected 0", overflow); end
`ifdef FREQ_METER_PERIOD_EN
        n_checks++; if (period !== 16'd4) begin n_fail++; $display("FAIL basic_period: got %0d expected 4", period); end
`else
        n_checks++; if (period !== 16'd0) begin n_fail++; $display("FAIL basic_period: got %0d expected 0", period); end
`endif
    endtask

    task automatic test_phases();
        int t, dc, bc, nd;
        sig_p = 256;
        for (int i = 0; i < 8; i++) begin
            sig_ph = $urandom_range(0, 255);
            repeat (3) @(posedge inClk);
            launch(1024, t);
            collect(1030, dc, bc, nd);
            n_checks++; if (edgeCount !== 16'd4) begin n_fail++; $display("FAIL phase_count ph=%0d: got %0d expected 4", sig_ph, edgeCount); end
            n_checks++; if (dc !== t + 1025) begin n_fail++; $display("FAIL phase_done_cycle: got %0d expected %0d", dc, t + 1025); end
        end
    endtask

    task automatic test_overflow();
        int t, dc, bc, nd;
        sig_p = 2; sig_ph = 0;
        repeat (4) @(posedge inClk);
        launch(40, t);
        collect(50, dc, bc, nd);
        n_checks++; if (edgeCount4 !== 4'd15) begin n_fail++; $display("FAIL ovf_count4: got %0d expected 15", edgeCount4); end
        n_checks++; if (overflow4 !== 1'b1) begin n_fail++; $display("FAIL ovf_flag4: got %0d expected 1", overflow4); end
        n_checks++; if (edgeCount !== 16'd20) begin n_fail++; $display("FAIL ovf_count16: got %0d expected 20", edgeCount); end
        n_checks++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL ovf_flag16: got %0d expected 0", overflow); end
        launch(10, t);
        collect(20, dc, bc, nd);
        n_checks++; if (edgeCount4 !== 4'd5) begin n_fail++; $display("FAIL ovf_rerun_count4: got %0d expected 5", edgeCount4); end
        n_checks++; if (overflow4 !== 1'b0) begin n_fail++; $display("FAIL ovf_rerun_flag4: got %0d expected 0", overflow4); end
    endtask

    task automatic test_ignore_start();
        int t, dc, bc, nd, cnt, ovf, per;
        sig_p = 6; sig_ph = $urandom_range(0, 5);
        launch(60, t);
        fork
            collect(80, dc, bc, nd);
            begin
                repeat (20) @(posedge inClk);
                #1; start = 1'b1; gateLen = GW'(7);
                @(posedge inClk); #1; start = 1'b0;
            end
        join
        model(t, 60, 16, cnt, ovf, per);
        n_checks++; if (nd !== 1) begin n_fail++; $display("FAIL ignore_done_pulses: got %0d expected 1", nd); end
        n_checks++; if (dc !== t + 61) begin n_fail++; $display("FAIL ignore_done_cycle: got %0d expected %0d", dc, t + 61); end
        n_checks++; if (bc !== 60) begin n_fail++; $display("FAIL ignore_busy_cycles: got %0d expected 60", bc); end
        n_checks++; if (edgeCount !== 16'(cnt)) begin n_fail++; $display("FAIL ignore_count: got %0d expected %0d", edgeCount, cnt); end
    endtask

    task automatic test_back_to_back();
        int t, t2, dc, bc, nd, cnt, ovf, per;
        sig_p = 8; sig_ph = $urandom_range(0, 7);
        launch(20, t);
        for (int i = 0; i < 40 && cyc != t + 21; i++) begin
            @(posedge inClk); #1;
        end
        start = 1'b1; gateLen = GW'(15); t2 = cyc;
        @(negedge inClk);
        model(t, 20, 16, cnt, ovf, per);
        n_checks++; if (done !== 1'b1 || t2 !== t + 21) begin n_fail++; $display("FAIL b2b_first_done: got %0d at %0d expected 1 at %0d", done, t2, t + 21); end
        n_checks++; if (edgeCount !== 16'(cnt)) begin n_fail++; $display("FAIL b2b_first_count: got %0d expected %0d", edgeCount, cnt); end
        @(posedge inClk); #1;
        start = 1'b0;
        collect(25, dc, bc, nd);
        model(t2, 15, 16, cnt, ovf, per);
        n_checks++; if (dc !== t2 + 16) begin n_fail++; $display("FAIL b2b_second_done_cycle: got %0d expected %0d", dc, t2 + 16); end
        n_checks++; if (bc !== 15) begin n_fail++; $display("FAIL b2b_second_busy: got %0d expected 15", bc); end
        n_checks++; if (edgeCount !== 16'(cnt)) begin n_fail++; $display("FAIL b2b_second_count: got %0d expected %0d", edgeCount, cnt); end
    endtask

    task automatic test_zero_gate();
        int t, dc, bc, nd;
        sig_p = 4; sig_ph = 1;
        launch(0, t);
        collect(6, dc, bc, nd);
        n_checks++; if (dc !== t + 1) begin n_fail++; $display("FAIL zero_done_cycle: got %0d expected %0d", dc, t + 1); end
        n_checks++; if (nd !== 1) begin n_fail++; $display("FAIL zero_done_pulses: got %0d expected 1", nd); end
        n_checks++; if (bc !== 0) begin n_fail++; $display("FAIL zero_busy: got %0d expected 0", bc); end
        n_checks++; if ({edgeCount, overflow, period} !== 33'd0) begin n_fail++; $display("FAIL zero_results: got %0d/%0d/%0d expected 0", edgeCount, overflow, period); end
    endtask

    task automatic test_random();
        int t, n, dc, bc, nd, cnt, ovf, per, cnt4, ovf4, per4;
        for (int i = 0; i < 6; i++) begin
            sig_p  = $urandom_range(2, 40);
            sig_ph = $urandom_range(0, 39);
            n      = $urandom_range(1, 300);
            repeat (2) @(posedge inClk);
            launch(n, t);
            collect(n + 8, dc, bc, nd);
            model(t, n, 16, cnt, ovf, per);
            model(t, n, 4, cnt4, ovf4, per4);
            n_checks++; if (dc !== t + n + 1) begin n_fail++; $display("FAIL rand_done_cycle n=%0d: got %0d expected %0d", n, dc, t + n + 1); end
            n_checks++; if (bc !== n) begin n_fail++; $display("FAIL rand_busy n=%0d: got %0d expected %0d", n, bc, n); end
            n_checks++; if (edgeCount !== 16'(cnt) || overflow !== 1'(ovf)) begin n_fail++; $display("FAIL rand_count p=%0d n=%0d: got %0d/%0d expected %0d/%0d", sig_p, n, edgeCount, overflow, cnt, ovf); end
            n_checks++; if (edgeCount4 !== 4'(cnt4) || overflow4 !== 1'(ovf4)) begin n_fail++; $display("FAIL rand_count4 p=%0d n=%0d: got %0d/%0d expected %0d/%0d", sig_p, n, edgeCount4, overflow4, cnt4, ovf4); end
            n_checks++; if (period !== 16'(per) || period4 !== 4'(per4)) begin n_fail++; $display("FAIL rand_period p=%0d n=%0d: got %0d/%0d expected %0d/%0d", sig_p, n, period, period4, per, per4); end
        end
    endtask

    task automatic test_reset_mid();
        int t, dc, bc, nd;
        sig_p = 4; sig_ph = 0;
        launch(50, t);
        repeat (10) @(posedge inClk);
        #1; reset = 1'b0;
        @(posedge inClk); #1;
        reset = 1'b1;
        @(negedge inClk);
        n_checks++;
        if ({busy, done, overflow, edgeCount, period} !== 35'd0) begin
            n_fail++; $display("FAIL midreset_outputs: got %h expected 0", {busy, done, overflow, edgeCount, period});
        end
        n_checks++;
        if ({busy4, done4, overflow4, edgeCount4, period4} !== 11'd0) begin
            n_fail++; $display("FAIL midreset_outputs4: got %h expected 0", {busy4, done4, overflow4, edgeCount4, period4});
        end
        collect(60, dc, bc, nd);
        n_checks++; if (nd !== 0) begin n_fail++; $display("FAIL midreset_no_done: got %0d expected 0", nd); end
        n_checks++; if (bc !== 0) begin n_fail++; $display("FAIL midreset_busy: got %0d expected 0", bc); end
    endtask

    initial begin
        reset = 1'b0; start = 1'b0; gateLen = '0;
        test_reset();
        test_basic();
        test_phases();
        test_overflow();
        test_ignore_start();
        test_back_to_back();
        test_zero_gate();
        test_random();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
